cdb_broadcaster: RTL and testbench

Completion-side counterpart of the reservation station. It collects finished results from all functional units and drives the common data bus (CDB) with exactly one tag per cycle, as `complete_en` and `CDB_T`, which the RS, map table and ROB consume. Each FU has a one-entry holding buffer with a ready/done handshake for back-pressure. A round-robin arbiter picks the winner. Entries younger than a branch mispredict are squashed on rollback.

---
 rtl/cdb_broadcaster.sv | 185 ++++++++++++++++++
 tb/tb_cdb_broadcaster.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: collects finished results from NUM_FU functional units into
// one-entry holding buffers and broadcasts exactly one of them per cycle on the
// common data bus. A round-robin arbiter picks the winner; entries younger than
// a mispredicted branch are squashed on rollback.
// Optional feature macro: CDB_BYPASS_EN -- lets an incoming done on an empty,
// non-squashed buffer compete for the bus in the same cycle (1-cycle latency).
`timescale 1ns/1ps

module cdb_broadcaster #(
  parameter int NUM_FU    = 5,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int DATA_W    = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_FU-1:0]             fu_done,
  input  logic [NUM_FU*PRF_IDX_W-1:0]   fu_T_idx,
  input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_ROB_idx,
  input  logic [NUM_FU*DATA_W-1:0]      fu_value,
  output logic [NUM_FU-1:0]             fu_ready,
  input  logic                          rollback_en,
  input  logic [ROB_IDX_W-1:0]          ROB_rollback_idx,
  input  logic [ROB_IDX_W-1:0]          ROB_tail_idx,
  output logic                          complete_en,
  output logic [PRF_IDX_W-1:0]          CDB_T,
  output logic [ROB_IDX_W-1:0]          CDB_ROB_idx,
  output logic [DATA_W-1:0]             CDB_value
);

  localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [RR_W:0]   NUM_FU_L = (RR_W+1)'(NUM_FU);
  localparam logic [RR_W-1:0] LAST_FU  = RR_W'(NUM_FU - 1);

  // An index x is younger than the surviving branch and older than the tail.
  function automatic logic is_squashed(input logic                 en,
                                       input logic [ROB_IDX_W-1:0] x,
                                       input logic [ROB_IDX_W-1:0] rb,
                                       input logic [ROB_IDX_W-1:0] tail);
    logic [ROB_IDX_W-1:0] d;
    logic [ROB_IDX_W-1:0] dt;
    d  = x - rb;
    dt = tail - rb;
    return en && (d != '0) && (d < dt);
  endfunction

  // Holding buffers: valid is control (reset), fields are data (no reset).
  logic [NUM_FU-1:0]    r_buf_vld;
  logic [PRF_IDX_W-1:0] r_buf_t   [NUM_FU];
  logic [ROB_IDX_W-1:0] r_buf_rob [NUM_FU];
  logic [DATA_W-1:0]    r_buf_val [NUM_FU];
  logic [RR_W-1:0]      r_rr;

  logic                 r_complete_en;
  logic [PRF_IDX_W-1:0] r_cdb_t;
  logic [ROB_IDX_W-1:0] r_cdb_rob;
  logic [DATA_W-1:0]    r_cdb_val;

  logic [PRF_IDX_W-1:0] w_in_t   [NUM_FU];
  logic [ROB_IDX_W-1:0] w_in_rob [NUM_FU];
  logic [DATA_W-1:0]    w_in_val [NUM_FU];
  logic [NUM_FU-1:0]    w_sq_buf;
  logic [NUM_FU-1:0]    w_sq_in;
  logic [NUM_FU-1:0]    w_cand;
  logic [NUM_FU-1:0]    w_grant;
  logic                 w_gnt_any;
  logic [RR_W-1:0]      w_gnt_idx;
  logic [NUM_FU-1:0]    w_accept;
  logic [NUM_FU-1:0]    w_byp_gnt;
  logic [NUM_FU-1:0]    w_load;
  logic [PRF_IDX_W-1:0] w_win_t;
  logic [ROB_IDX_W-1:0] w_win_rob;
  logic [DATA_W-1:0]    w_win_val;
  logic [RR_W-1:0]      w_rr_next;

  // Unpack FU fields and evaluate the squash test for buffered and incoming entries.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      w_in_t[i]   = fu_T_idx[i*PRF_IDX_W +: PRF_IDX_W];
      w_in_rob[i] = fu_ROB_idx[i*ROB_IDX_W +: ROB_IDX_W];
      w_in_val[i] = fu_value[i*DATA_W +: DATA_W];
      w_sq_buf[i] = is_squashed(rollback_en, r_buf_rob[i], ROB_rollback_idx, ROB_tail_idx);
      w_sq_in[i]  = is_squashed(rollback_en, w_in_rob[i], ROB_rollback_idx, ROB_tail_idx);
`ifdef CDB_BYPASS_EN
      w_cand[i]   = (r_buf_vld[i] && !w_sq_buf[i]) ||
                    (!r_buf_vld[i] && fu_done[i] && !w_sq_in[i]);
`else
      w_cand[i]   = r_buf_vld[i] && !w_sq_buf[i];
`endif
    end
  end

  // Round-robin scan starting at r_rr; first candidate wins.
  always_comb begin : p_arb
    logic [RR_W:0]   sum;
    logic [RR_W-1:0] idx;
    sum       = '0;
    idx       = '0;
    w_grant   = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sum = {1'b0, r_rr} + (RR_W+1)'(k);
      if (sum >= NUM_FU_L) sum = sum - NUM_FU_L;
      idx = sum[RR_W-1:0];
      if (!w_gnt_any && w_cand[idx]) begin
        w_gnt_any      = 1'b1;
        w_gnt_idx      = idx;
        w_grant[idx]   = 1'b1;
      end
    end
  end

  // Handshake, buffer load decision, winner field mux and next rr.
  always_comb begin
    fu_ready  = ~r_buf_vld | w_grant;
    w_accept  = fu_done & fu_ready;
`ifdef CDB_BYPASS_EN
    w_byp_gnt = w_grant & ~r_buf_vld;
`else
    w_byp_gnt = '0;
`endif
    // A squashed incoming done is accepted but dropped; a bypassed one skips the buffer.
    w_load    = w_accept & ~w_sq_in & ~w_byp_gnt;
    w_win_t   = r_buf_t[w_gnt_idx];
    w_win_rob = r_buf_rob[w_gnt_idx];
    w_win_val = r_buf_val[w_gnt_idx];
`ifdef CDB_BYPASS_EN
    if (!r_buf_vld[w_gnt_idx]) begin
      w_win_t   = w_in_t[w_gnt_idx];
      w_win_rob = w_in_rob[w_gnt_idx];
      w_win_val = w_in_val[w_gnt_idx];
    end
`endif
    w_rr_next = (w_gnt_idx == LAST_FU) ? '0 : w_gnt_idx + 1'b1;
  end

  // Buffer occupancy: refill wins over grant/squash clear (back-to-back completion).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_buf_vld <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_load[i])                      r_buf_vld[i] <= 1'b1;
        else if (w_grant[i] || w_sq_buf[i]) r_buf_vld[i] <= 1'b0;
      end
    end
  end

  // Buffer payload captured on every load.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_load[i]) begin
        r_buf_t[i]   <= w_in_t[i];
        r_buf_rob[i] <= w_in_rob[i];
        r_buf_val[i] <= w_in_val[i];
      end
    end
  end

  // Arbiter pointer and CDB output register; outputs hold when nothing is granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr          <= '0;
      r_complete_en <= 1'b0;
      r_cdb_t       <= '0;
      r_cdb_rob     <= '0;
      r_cdb_val     <= '0;
    end else begin
      r_complete_en <= w_gnt_any;
      if (w_gnt_any) begin
        r_rr      <= w_rr_next;
        r_cdb_t   <= w_win_t;
        r_cdb_rob <= w_win_rob;
        r_cdb_val <= w_win_val;
      end
    end
  end

  assign complete_en = r_complete_en;
  assign CDB_T       = r_cdb_t;
  assign CDB_ROB_idx = r_cdb_rob;
  assign CDB_value   = r_cdb_val;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: directed stimulus pushes hand-computed
// expected broadcasts; an independent monitor pops and compares on complete_en.
`timescale 1ns/1ps

module tb_cdb_broadcaster;

  logic         clock;
  logic         reset;
  logic [4:0]   fu_done;
  logic [29:0]  fu_T_idx;
  logic [24:0]  fu_ROB_idx;
  logic [319:0] fu_value;
  logic [4:0]   fu_ready;
  logic         rollback_en;
  logic [4:0]   ROB_rollback_idx;
  logic [4:0]   ROB_tail_idx;
  logic         complete_en;
  logic [5:0]   CDB_T;
  logic [4:0]   CDB_ROB_idx;
  logic [63:0]  CDB_value;

  typedef struct {
    logic [5:0]  t;
    logic [4:0]  rob;
    logic [63:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  cdb_broadcaster dut (
    .clock(clock), .reset(reset),
    .fu_done(fu_done), .fu_T_idx(fu_T_idx), .fu_ROB_idx(fu_ROB_idx),
    .fu_value(fu_value), .fu_ready(fu_ready),
    .rollback_en(rollback_en), .ROB_rollback_idx(ROB_rollback_idx),
    .ROB_tail_idx(ROB_tail_idx),
    .complete_en(complete_en), .CDB_T(CDB_T), .CDB_ROB_idx(CDB_ROB_idx),
    .CDB_value(CDB_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [5:0] t, input logic [4:0] rob, input logic [63:0] v);
    exp_t x;
    x.t = t; x.rob = rob; x.v = v;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [5:0] t, input logic [4:0] rob, input logic [63:0] v);
    fu_done[i]           = 1'b1;
    fu_T_idx[i*6 +: 6]   = t;
    fu_ROB_idx[i*5 +: 5] = rob;
    fu_value[i*64 +: 64] = v;
  endtask

  task automatic do_reset();
    fu_done     = '0;
    rollback_en = 1'b0;
    reset       = 1'b0;
    #1;
    reset       = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 30 && sb.size() != 0; c++) tick();
    repeat (3) tick();
    check(name, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Monitor: every broadcast must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset && complete_en) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL cdb_unexpected: got T=%0d ROB=%0d val=%0h, required no broadcast",
                 CDB_T, CDB_ROB_idx, CDB_value);
      end else begin
        e = sb.pop_front();
        if (CDB_T !== e.t || CDB_ROB_idx !== e.rob || CDB_value !== e.v) begin
          n_fail++;
          $display("FAIL cdb_order: got T=%0d ROB=%0d val=%0h, required T=%0d ROB=%0d val=%0h",
                   CDB_T, CDB_ROB_idx, CDB_value, e.t, e.rob, e.v);
        end
      end
    end
  end

  initial begin
    int   k;
    logic acc0;
    reset = 1'b0; fu_done = '0; fu_T_idx = '0; fu_ROB_idx = '0; fu_value = '0;
    rollback_en = 1'b0; ROB_rollback_idx = '0; ROB_tail_idx = '0;
    #1;
    check("rst_complete_en", 64'(complete_en), 64'd0);
    check("rst_cdb_t",       64'(CDB_T), 64'd0);
    check("rst_cdb_rob",     64'(CDB_ROB_idx), 64'd0);
    check("rst_cdb_value",   CDB_value, 64'd0);
    check("rst_fu_ready",    64'(fu_ready), 64'h1f);
    #10 reset = 1'b1;
    tick(); tick();
    check("idle_after_reset", 64'(complete_en), 64'd0);

    // Reset in the middle of traffic discards everything buffered.
    for (int i = 0; i < 5; i++) set_fu(i, 6'(i + 1), 5'(i), 64'(i));
    tick();
    fu_done = '0;
    #1 check("mid_ready_pre", 64'(fu_ready), 64'h01);
    sb.push_back(mk(6'd1, 5'd0, 64'd0));
    tick();
    check("mid_first_bcast", 64'(complete_en), 64'd1);
    #5 reset = 1'b0;
    #1;
    check("mid_rst_complete_en", 64'(complete_en), 64'd0);
    check("mid_rst_cdb_t",       64'(CDB_T), 64'd0);
    check("mid_rst_fu_ready",    64'(fu_ready), 64'h1f);
    #1 reset = 1'b1;
    tick(); tick(); tick();
    check("mid_no_bcast_after", 64'(complete_en), 64'd0);
    wait_drain("mid_drain");

    // Single completion.
    do_reset();
    set_fu(2, 6'd17, 5'd3, 64'hDEAD);
    sb.push_back(mk(6'd17, 5'd3, 64'hDEAD));
    tick();
    fu_done = '0;
`ifndef CDB_BYPASS_EN
    check("single_not_yet", 64'(complete_en), 64'd0);
    tick();
`endif
    check("single_complete_en", 64'(complete_en), 64'd1);
    check("single_cdb_t",       64'(CDB_T), 64'd17);
    check("single_cdb_rob",     64'(CDB_ROB_idx), 64'd3);
    wait_drain("single_drain");

    // Contention: five simultaneous dones drained in rr order.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_fu(i, 6'(i + 1), 5'(i + 1), 64'(100 + i));
      sb.push_back(mk(6'(i + 1), 5'(i + 1), 64'(100 + i)));
    end
    tick();
    fu_done = '0;
    #1 check("cont_ready_0", 64'(fu_ready), 64'h01);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("cont_cdb_t", 64'(CDB_T), 64'(c + 1));
      check("cont_ready", 64'(fu_ready), (c >= 3) ? 64'h1f : 64'((1 << (c + 2)) - 1));
    end
    wait_drain("cont_drain");

    // Fairness: FU0 streams, FU1 completes once; order 10,20,11,12,13.
    do_reset();
    sb.push_back(mk(6'd10, 5'd10, 64'd10));
    sb.push_back(mk(6'd20, 5'd20, 64'd20));
    sb.push_back(mk(6'd11, 5'd11, 64'd11));
    sb.push_back(mk(6'd12, 5'd12, 64'd12));
    sb.push_back(mk(6'd13, 5'd13, 64'd13));
    set_fu(0, 6'd10, 5'd10, 64'd10);
    set_fu(1, 6'd20, 5'd20, 64'd20);
    k = 0;
    for (int c = 0; c < 16 && k < 4; c++) begin
      #1 acc0 = fu_done[0] & fu_ready[0];
      @(posedge clock); #1;
      fu_done[1] = 1'b0;
      if (acc0) begin
        k++;
        if (k < 4) set_fu(0, 6'(10 + k), 5'(10 + k), 64'(10 + k));
        else       fu_done[0] = 1'b0;
      end
    end
    check("fair_fu0_all_accepted", 64'(k), 64'd4);
    wait_drain("fair_drain");

    // Rollback with ROB wrap: survivor 30, tail 2 squashes 31, 0 and incoming 1.
    do_reset();
    set_fu(0, 6'd40, 5'd31, 64'h40);
    set_fu(1, 6'd41, 5'd0,  64'h41);
    set_fu(2, 6'd42, 5'd29, 64'h42);
    sb.push_back(mk(6'd42, 5'd29, 64'h42));
    tick();
    fu_done = '0;
    rollback_en = 1'b1; ROB_rollback_idx = 5'd30; ROB_tail_idx = 5'd2;
    set_fu(3, 6'd43, 5'd1, 64'h43);
    #1 check("rb_ready", 64'(fu_ready), 64'h1c);
    tick();
    rollback_en = 1'b0; fu_done = '0;
    check("rb_complete_en", 64'(complete_en), 64'd1);
    check("rb_cdb_rob",     64'(CDB_ROB_idx), 64'd29);
    #1 check("rb_ready_after", 64'(fu_ready), 64'h1f);
    wait_drain("rb_drain");

    // Back-to-back on FU3.
    do_reset();
    set_fu(3, 6'd50, 5'd7, 64'h50);
    sb.push_back(mk(6'd50, 5'd7, 64'h50));
    sb.push_back(mk(6'd51, 5'd8, 64'h51));
    #1 check("b2b_ready_a", 64'(fu_ready[3]), 64'd1);
    tick();
    set_fu(3, 6'd51, 5'd8, 64'h51);
    #1 check("b2b_ready_b", 64'(fu_ready[3]), 64'd1);
    tick();
    fu_done = '0;
    check("b2b_first_t", 64'(CDB_T), 64'd50);
    tick();
    check("b2b_second_t", 64'(CDB_T), 64'd51);
    wait_drain("b2b_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
